// File: rtl/gpu_operand_collector_if.sv
// Issue / bank-read / dispatch bundle for gpu_operand_collector.
// master = collector side, slave = issue stage, gpu_bank and execute.
interface gpu_operand_collector_if #(
    parameter int LANES   = 32,
    parameter int DATA_W  = 64,
    parameter int NUM_SRC = 3
);
    localparam int ROW_W = LANES * DATA_W;

    logic                       issue_valid;
    logic                       issue_ready;
    logic [1:0]                 issue_warp;
    logic [NUM_SRC*5-1:0]       issue_src;
    logic [NUM_SRC-1:0]         issue_mask;

    logic                       bank_read;
    logic [63:0]                bank_reg_num;
    logic [1:0]                 bank_warp;
    logic [ROW_W-1:0]           bank_rdata;

    logic                       disp_valid;
    logic                       disp_ready;
    logic [1:0]                 disp_warp;
    logic [NUM_SRC-1:0]         disp_mask;
    logic [NUM_SRC*ROW_W-1:0]   disp_ops;

    modport master (
        input  issue_valid, issue_warp, issue_src, issue_mask, bank_rdata, disp_ready,
        output issue_ready, bank_read, bank_reg_num, bank_warp,
               disp_valid, disp_warp, disp_mask, disp_ops
    );

    modport slave (
        output issue_valid, issue_warp, issue_src, issue_mask, bank_rdata, disp_ready,
        input  issue_ready, bank_read, bank_reg_num, bank_warp,
               disp_valid, disp_warp, disp_mask, disp_ops
    );
endinterface

// File: rtl/gpu_operand_collector.sv
// Operand collector: sequences one bank read per used source slot, gathers rows, dispatches.
// Optional macro OPC_ZERO_REG_EN: source register 0 reads as zero without a bank access.
module gpu_operand_collector #(
    parameter int LANES    = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_SRC  = 3,
    parameter int READ_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gpu_operand_collector_if.master bus
);
    localparam int ROW_W  = LANES * DATA_W;
    localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DISPATCH} state_t;

    state_t               state;
    logic [NUM_SRC*5-1:0] src_q;
    logic [NUM_SRC-1:0]   pend;
    logic [SLOT_W-1:0]    rd_slot;
    logic [NUM_SRC-1:0]   acc_rd_mask;
    logic                 in_flight;

    logic                 tag_vld_p  [READ_LAT];
    logic [SLOT_W-1:0]    tag_slot_p [READ_LAT];

    function automatic logic [SLOT_W-1:0] first_set(input logic [NUM_SRC-1:0] m);
        first_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (m[i]) first_set = SLOT_W'(i);
    endfunction

    function automatic logic [63:0] reg_field(input logic [NUM_SRC*5-1:0] s,
                                              input logic [SLOT_W-1:0]    slot);
        reg_field = {59'd0, s[slot*5 +: 5]};
    endfunction

    assign bus.issue_ready = (state == IDLE);

    always_comb begin
        acc_rd_mask = bus.issue_mask;
`ifdef OPC_ZERO_REG_EN
        for (int i = 0; i < NUM_SRC; i++)
            if (bus.issue_src[i*5 +: 5] == 5'd0) acc_rd_mask[i] = 1'b0;
`endif
        // Tags short of the output stage still have a capture to come.
        in_flight = 1'b0;
        for (int i = 0; i < READ_LAT - 1; i++)
            in_flight = in_flight | tag_vld_p[i];
    end

    // Tag pipeline: stage 0 is loaded by the read strobe, last stage lines up with bank_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                tag_vld_p[i]  <= 1'b0;
                tag_slot_p[i] <= '0;
            end
        end else begin
            tag_vld_p[0]  <= bus.bank_read;
            tag_slot_p[0] <= rd_slot;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_vld_p[i]  <= tag_vld_p[i-1];
                tag_slot_p[i] <= tag_slot_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.bank_read    <= 1'b0;
            bus.bank_reg_num <= '0;
            bus.bank_warp    <= '0;
            bus.disp_valid   <= 1'b0;
            bus.disp_warp    <= '0;
            bus.disp_mask    <= '0;
            bus.disp_ops     <= '0;
            src_q            <= '0;
            pend             <= '0;
            rd_slot          <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (tag_vld_p[READ_LAT-1] && tag_slot_p[READ_LAT-1] == SLOT_W'(i))
                    bus.disp_ops[i*ROW_W +: ROW_W] <= bus.bank_rdata;

            case (state)
                IDLE: begin
                    if (bus.issue_valid) begin
                        bus.disp_warp <= bus.issue_warp;
                        bus.disp_mask <= bus.issue_mask;
                        bus.disp_ops  <= '0;
                        src_q         <= bus.issue_src;
                        if (acc_rd_mask == '0) begin
                            state          <= DISPATCH;
                            bus.disp_valid <= 1'b1;
                        end else begin
                            state            <= ISSUE;
                            bus.bank_read    <= 1'b1;
                            bus.bank_warp    <= bus.issue_warp;
                            bus.bank_reg_num <= reg_field(bus.issue_src, first_set(acc_rd_mask));
                            rd_slot          <= first_set(acc_rd_mask);
                            pend             <= acc_rd_mask & (acc_rd_mask - NUM_SRC'(1));
                        end
                    end
                end
                ISSUE: begin
                    if (pend != '0) begin
                        bus.bank_read    <= 1'b1;
                        bus.bank_reg_num <= reg_field(src_q, first_set(pend));
                        rd_slot          <= first_set(pend);
                        pend             <= pend & (pend - NUM_SRC'(1));
                    end else begin
                        bus.bank_read <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (!in_flight) begin
                        state          <= DISPATCH;
                        bus.disp_valid <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (bus.disp_ready) begin
                        state          <= IDLE;
                        bus.disp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
